// File: rtl/div_iterative.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Operands are reduced to magnitudes up front and signs are applied in FIXUP.
module div_iterative #(
  parameter int    N_WIDTH  = 8,
  parameter int    D_WIDTH  = 4,
  parameter string N_SIGNED = "FALSE",
  parameter string D_SIGNED = "FALSE"
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n,
  input  logic [D_WIDTH-1:0] d,
  output logic               busy,
  output logic               done,
  output logic [N_WIDTH:0]   q,
  output logic [D_WIDTH:0]   r,
  output logic               div_by_zero
);

  localparam bit NS = (N_SIGNED == "TRUE");
  localparam bit DS = (D_SIGNED == "TRUE");
  localparam int CW = $clog2(N_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_t;

  state_t state;

  logic [N_WIDTH-1:0] acc;
  logic [D_WIDTH:0]   rem;
  logic [D_WIDTH-1:0] dvs;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic [CW-1:0]      cnt;

  logic               n_neg;
  logic               d_neg;
  logic [N_WIDTH-1:0] n_mag;
  logic [D_WIDTH-1:0] d_mag;
  logic [D_WIDTH:0]   rem_sh;
  logic [D_WIDTH+1:0] diff;
  logic               q_bit;
  logic [N_WIDTH:0]   q_mag;
  logic [N_WIDTH:0]   q_fix;
  logic [D_WIDTH:0]   r_fix;

  // Unsigned negation keeps the most negative value exact as a magnitude.
  always_comb begin
    n_neg = NS & n[N_WIDTH-1];
    d_neg = DS & d[D_WIDTH-1];
    n_mag = n_neg ? -n : n;
    d_mag = d_neg ? -d : d;
  end

  // Restoring step: borrow out of the trial subtraction decides the bit.
  always_comb begin
    rem_sh = {rem[D_WIDTH-1:0], acc[N_WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs};
    q_bit  = ~diff[D_WIDTH+1];
  end

  always_comb begin
    q_mag = {1'b0, acc};
    q_fix = neg_q ? -q_mag : q_mag;
    r_fix = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      rem         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      cnt         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= n_mag;
            rem   <= '0;
            dvs   <= d_mag;
            neg_q <= n_neg ^ d_neg;
            neg_r <= n_neg;
            dz    <= (d == '0);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= {acc[N_WIDTH-2:0], q_bit};
          rem <= q_bit ? diff[D_WIDTH:0] : rem_sh;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          q           <= dz ? '1 : q_fix;
          r           <= dz ? '0 : r_fix;
          div_by_zero <= dz;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iterative.sv
// Directed bench for div_iterative: three parameterisations share stimulus.
// Unsigned/unsigned, signed/signed and unsigned-n/signed-d are checked.
module tb_div_iterative;

  logic       clk;
  logic       arst;
  logic       start;
  logic [7:0] n;
  logic [3:0] d;

  logic       busy_uu, done_uu, z_uu;
  logic [8:0] q_uu;
  logic [4:0] r_uu;
  logic       busy_ss, done_ss, z_ss;
  logic [8:0] q_ss;
  logic [4:0] r_ss;
  logic       busy_us, done_us, z_us;
  logic [8:0] q_us;
  logic [4:0] r_us;

  int errors = 0;
  int checks = 0;

  div_iterative #(
    .N_WIDTH(8), .D_WIDTH(4),
    .N_SIGNED("FALSE"), .D_SIGNED("FALSE")
  ) u_uu (
    .clk(clk), .arst(arst), .start(start), .n(n), .d(d),
    .busy(busy_uu), .done(done_uu), .q(q_uu), .r(r_uu),
    .div_by_zero(z_uu)
  );

  div_iterative #(
    .N_WIDTH(8), .D_WIDTH(4),
    .N_SIGNED("TRUE"), .D_SIGNED("TRUE")
  ) u_ss (
    .clk(clk), .arst(arst), .start(start), .n(n), .d(d),
    .busy(busy_ss), .done(done_ss), .q(q_ss), .r(r_ss),
    .div_by_zero(z_ss)
  );

  div_iterative #(
    .N_WIDTH(8), .D_WIDTH(4),
    .N_SIGNED("FALSE"), .D_SIGNED("TRUE")
  ) u_us (
    .clk(clk), .arst(arst), .start(start), .n(n), .d(d),
    .busy(busy_us), .done(done_us), .q(q_us), .r(r_us),
    .div_by_zero(z_us)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulses start, scrambles operands after E0, returns edges E0->done.
  task automatic launch(input logic [7:0] nn, input logic [3:0] dd,
                        output int lat);
    start = 1'b1;
    n = nn;
    d = dd;
    tick();
    start = 1'b0;
    n = ~nn;
    d = ~dd;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_uu) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    arst = 1'b1;
    start = 1'b1;
    n = 8'd200;
    d = 4'd7;
    tick();
    tick();
    checks++;
    if (busy_uu !== 1'b0 || done_uu !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy_uu, done_uu);
    end
    checks++;
    if (q_uu !== 9'd0 || r_uu !== 5'd0 || z_uu !== 1'b0) begin
      errors++;
      $display("FAIL reset_out q=%h r=%h z=%b want 0 0 0", q_uu, r_uu, z_uu);
    end
    checks++;
    if (busy_ss !== 1'b0 || q_ss !== 9'd0) begin
      errors++;
      $display("FAIL reset_ss busy=%b q=%h want 0 0", busy_ss, q_ss);
    end
    arst = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy_uu !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b want 0", busy_uu);
    end
  endtask

  task automatic test_unsigned;
    int lat;
    launch(8'd200, 4'd7, lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL uns_latency got %0d want 9", lat);
    end
    checks++;
    if (q_uu !== 9'd28 || r_uu !== 5'd4 || z_uu !== 1'b0) begin
      errors++;
      $display("FAIL uns_200_7 q=%h r=%h z=%b want 01c 04 0",
               q_uu, r_uu, z_uu);
    end
    checks++;
    if (busy_uu !== 1'b1) begin
      errors++;
      $display("FAIL uns_busy_done busy=%b want 1", busy_uu);
    end
    tick();
    checks++;
    if (busy_uu !== 1'b0 || done_uu !== 1'b0) begin
      errors++;
      $display("FAIL uns_after busy=%b done=%b want 0 0", busy_uu, done_uu);
    end
    checks++;
    if (q_uu !== 9'd28 || r_uu !== 5'd4) begin
      errors++;
      $display("FAIL uns_hold q=%h r=%h want 01c 04", q_uu, r_uu);
    end
  endtask

  task automatic test_signed;
    int lat;
    launch(8'h9C, 4'h7, lat);
    checks++;
    if (lat !== 9 || q_ss !== 9'h1F2 || r_ss !== 5'h1E) begin
      errors++;
      $display("FAIL sgn_m100_7 lat=%0d q=%h r=%h want 9 1f2 1e",
               lat, q_ss, r_ss);
    end
    checks++;
    if (q_uu !== 9'd22 || r_uu !== 5'd2 || q_us !== 9'd22 || r_us !== 5'd2) begin
      errors++;
      $display("FAIL uns_156_7 uu=%h/%h us=%h/%h want 016/02",
               q_uu, r_uu, q_us, r_us);
    end
    tick();
    launch(8'h64, 4'h9, lat);
    checks++;
    if (q_ss !== 9'h1F2 || r_ss !== 5'h02 || z_ss !== 1'b0) begin
      errors++;
      $display("FAIL sgn_100_m7 q=%h r=%h z=%b want 1f2 02 0",
               q_ss, r_ss, z_ss);
    end
    tick();
  endtask

  task automatic test_overflow;
    int lat;
    launch(8'h80, 4'hF, lat);
    checks++;
    if (lat !== 9 || q_ss !== 9'h080 || r_ss !== 5'h00) begin
      errors++;
      $display("FAIL ovf_m128_m1 lat=%0d q=%h r=%h want 9 080 00",
               lat, q_ss, r_ss);
    end
    checks++;
    if (q_us !== 9'h180 || r_us !== 5'h00) begin
      errors++;
      $display("FAIL mix_128_m1 q=%h r=%h want 180 00", q_us, r_us);
    end
    checks++;
    if (q_uu !== 9'd8 || r_uu !== 5'd8) begin
      errors++;
      $display("FAIL uns_128_15 q=%h r=%h want 008 08", q_uu, r_uu);
    end
    tick();
  endtask

  task automatic test_mixed;
    int lat;
    launch(8'hFF, 4'hF, lat);
    checks++;
    if (lat !== 9 || q_us !== 9'h101 || r_us !== 5'h00) begin
      errors++;
      $display("FAIL mix_255_m1 lat=%0d q=%h r=%h want 9 101 00",
               lat, q_us, r_us);
    end
    checks++;
    if (q_ss !== 9'h001 || r_ss !== 5'h00) begin
      errors++;
      $display("FAIL sgn_m1_m1 q=%h r=%h want 001 00", q_ss, r_ss);
    end
    checks++;
    if (q_uu !== 9'd17 || r_uu !== 5'd0) begin
      errors++;
      $display("FAIL uns_255_15 q=%h r=%h want 011 00", q_uu, r_uu);
    end
    tick();
  endtask

  task automatic test_div_zero;
    int lat;
    launch(8'd55, 4'd0, lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL dz_latency got %0d want 9", lat);
    end
    checks++;
    if (q_uu !== 9'h1FF || r_uu !== 5'h00 || z_uu !== 1'b1) begin
      errors++;
      $display("FAIL dz_uu q=%h r=%h z=%b want 1ff 00 1", q_uu, r_uu, z_uu);
    end
    checks++;
    if (q_ss !== 9'h1FF || r_ss !== 5'h00 || z_ss !== 1'b1 ||
        q_us !== 9'h1FF || z_us !== 1'b1) begin
      errors++;
      $display("FAIL dz_signed ss=%h/%h/%b us=%h/%b want 1ff/00/1",
               q_ss, r_ss, z_ss, q_us, z_us);
    end
    tick();
  endtask

  task automatic test_start_ignored;
    int dn = 0;
    int de = -1;
    logic [8:0] qs = '0;
    logic [4:0] rs = '0;
    start = 1'b1;
    n = 8'd200;
    d = 4'd7;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (done_uu) begin
        dn++;
        de = e;
        qs = q_uu;
        rs = r_uu;
      end
      if (e == 2) begin
        start = 1'b1;
        n = 8'd10;
        d = 4'd3;
      end
      if (e == 3) start = 1'b0;
    end
    checks++;
    if (dn !== 1 || de !== 9) begin
      errors++;
      $display("FAIL ign_done count=%0d edge=%0d want 1 9", dn, de);
    end
    checks++;
    if (qs !== 9'd28 || rs !== 5'd4) begin
      errors++;
      $display("FAIL ign_result q=%h r=%h want 01c 04", qs, rs);
    end
    checks++;
    if (busy_uu !== 1'b0) begin
      errors++;
      $display("FAIL ign_idle busy=%b want 0", busy_uu);
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    int dn = 0;
    start = 1'b1;
    n = 8'd200;
    d = 4'd7;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      if (done_uu) dn++;
    end
    arst = 1'b1;
    tick();
    if (done_uu) dn++;
    checks++;
    if (busy_uu !== 1'b0 || dn !== 0 || q_uu !== 9'd0) begin
      errors++;
      $display("FAIL abort busy=%b dones=%0d q=%h want 0 0 000",
               busy_uu, dn, q_uu);
    end
    arst = 1'b0;
    launch(8'd100, 4'd9, lat);
    checks++;
    if (lat !== 9 || q_uu !== 9'd11 || r_uu !== 5'd1) begin
      errors++;
      $display("FAIL abort_restart lat=%0d q=%h r=%h want 9 00b 01",
               lat, q_uu, r_uu);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int lat;
    launch(8'd200, 4'd7, lat);
    start = 1'b1;
    n = 8'd90;
    d = 4'd6;
    tick();
    checks++;
    if (busy_uu !== 1'b0 || done_uu !== 1'b0) begin
      errors++;
      $display("FAIL b2b_e10 busy=%b done=%b want 0 0", busy_uu, done_uu);
    end
    tick();
    checks++;
    if (busy_uu !== 1'b1) begin
      errors++;
      $display("FAIL b2b_e11 busy=%b want 1", busy_uu);
    end
    start = 1'b0;
    n = 8'd0;
    d = 4'd1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_uu) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 9 || q_uu !== 9'd15 || r_uu !== 5'd0) begin
      errors++;
      $display("FAIL b2b_second lat=%0d q=%h r=%h want 9 00f 00",
               lat, q_uu, r_uu);
    end
    tick();
    checks++;
    if (done_uu !== 1'b0 || busy_uu !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse done=%b busy=%b want 0 0", done_uu, busy_uu);
    end
  endtask

  initial begin
    arst = 1'b1;
    start = 1'b0;
    n = '0;
    d = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_mixed();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
